frame_draw_scheduler: RTL and testbench

Per-frame sequencer that shares the single VGA pixel-write port between up to four drawing clients (e.g. background eraser, dino sprite, obstacles, ground/overlay). It sits between the renderers and the `vga_adapter`. On each `frameClk` pulse it starts each enabled client in ascending index order, one at a time. While a client runs, the scheduler forwards that client's pixel bus to the adapter; it then waits for the client's done handshake and moves to the next client. A per-client watchdog catches clients that never finish, and sticky flags report watchdog timeouts and frame overruns.

---
 rtl/frame_draw_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_frame_draw_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - per-frame sequencer sharing one VGA pixel-write port among N drawing clients
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   frameClk, enable    frame-start pulse and frame-start gate
//   client_mask[N]      per-client enable, captured at frame start
//   client_done[N]      per-client done pulse (honoured only for the running client in WAIT)
//   client_x/y[8N]      per-client pixel coordinates, slice i = [8i+7:8i]
//   client_color[3N]    per-client pixel color, slice i = [3i+2:3i]
//   client_plot[N]      per-client pixel-write strobe
//   client_start[N]     one-hot, one-cycle start pulse
//   grant[N]            one-hot owner of the pixel port (zero in IDLE)
//   x, y, color         forwarded pixel bus of the owning client
//   plotPixel           forwarded pixel-write strobe
//   frame_busy          high while a frame is being sequenced
//   frame_done          one-cycle pulse at the end of each frame
//   frame_count[16]     completed frames, wrapping
//   timeout_err         sticky: a client was forced past by the watchdog
//   overrun             sticky: frameClk arrived while busy
module frame_draw_scheduler #(
    parameter int N       = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frameClk,
    input  logic             enable,
    input  logic [N-1:0]     client_mask,
    input  logic [N-1:0]     client_done,
    input  logic [8*N-1:0]   client_x,
    input  logic [8*N-1:0]   client_y,
    input  logic [3*N-1:0]   client_color,
    input  logic [N-1:0]     client_plot,
    output logic [N-1:0]     client_start,
    output logic [N-1:0]     grant,
    output logic [7:0]       x,
    output logic [7:0]       y,
    output logic [2:0]       color,
    output logic             plotPixel,
    output logic             frame_busy,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic             timeout_err,
    output logic             overrun
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    // Wide enough to hold TIMEOUT-1, so the counter never wraps inside WAIT.
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t          state;
    logic [N-1:0]    mask_r;
    logic [IW-1:0]   idx;
    logic [WW-1:0]   wd;

    logic [IW-1:0]   first_idx;
    logic [IW-1:0]   next_idx;
    logic            has_next;
    logic            done_sel;
    logic            plot_sel;
    logic [7:0]      x_sel;
    logic [7:0]      y_sel;
    logic [2:0]      color_sel;
    logic            owned;

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (i == IW'(k)) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (client_mask[i]) first_idx = IW'(i);
            if (mask_r[i] && (IW'(i) > idx)) begin
                next_idx = IW'(i);
                has_next = 1'b1;
            end
        end
    end

    // Select the running client's buses; idx only ever holds legal indices.
    always_comb begin
        done_sel  = 1'b0;
        plot_sel  = 1'b0;
        x_sel     = '0;
        y_sel     = '0;
        color_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                done_sel  = client_done[i];
                plot_sel  = client_plot[i];
                x_sel     = client_x[8*i +: 8];
                y_sel     = client_y[8*i +: 8];
                color_sel = client_color[3*i +: 3];
            end
        end
    end

    assign owned     = |grant;
    assign x         = owned ? x_sel : 8'd0;
    assign y         = owned ? y_sel : 8'd0;
    assign color     = owned ? color_sel : 3'd0;
    assign plotPixel = plot_sel & owned;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            mask_r       <= '0;
            idx          <= '0;
            wd           <= '0;
            client_start <= '0;
            grant        <= '0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            timeout_err  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            client_start <= '0;
            frame_done   <= 1'b0;
            // A frame start while busy is dropped, only flagged.
            if (frameClk && (state != IDLE)) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (frameClk && enable) begin
                        mask_r <= client_mask;
                        if (|client_mask) begin
                            idx          <= first_idx;
                            client_start <= onehot(first_idx);
                            grant        <= onehot(first_idx);
                            frame_busy   <= 1'b1;
                            state        <= START;
                        end else begin
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (done_sel || (wd == WD_MAX)) begin
                        // A real done wins over a coincident watchdog expiry.
                        if (!done_sel) timeout_err <= 1'b1;
                        if (has_next) begin
                            idx          <= next_idx;
                            client_start <= onehot(next_idx);
                            grant        <= onehot(next_idx);
                            state        <= START;
                        end else begin
                            grant       <= '0;
                            frame_busy  <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                            state       <= IDLE;
                        end
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - directed self-checking bench for frame_draw_scheduler
module tb_frame_draw_scheduler;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frameClk = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  client_mask = '0;
    logic [3:0]  client_done = '0;
    logic [31:0] client_x = '0;
    logic [31:0] client_y = '0;
    logic [11:0] client_color = '0;
    logic [3:0]  client_plot = '0;
    logic [3:0]  client_start;
    logic [3:0]  grant;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  color;
    logic        plotPixel;
    logic        frame_busy;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        timeout_err;
    logic        overrun;

    frame_draw_scheduler #(.N(4), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn), .frameClk(frameClk), .enable(enable),
        .client_mask(client_mask), .client_done(client_done),
        .client_x(client_x), .client_y(client_y), .client_color(client_color),
        .client_plot(client_plot), .client_start(client_start), .grant(grant),
        .x(x), .y(y), .color(color), .plotPixel(plotPixel),
        .frame_busy(frame_busy), .frame_done(frame_done), .frame_count(frame_count),
        .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int age[4];
    bit hang[4];
    bit rogue0 = 1'b0;
    int start_cyc[$];
    int start_idx[$];
    int done_cnt = 0;
    int last_done_cyc = -1;
    int pix_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gen_x(input int i, input int a);
        return 8'(16 * i + a);
    endfunction

    function automatic logic [7:0] gen_y(input int i);
        return 8'(100 + i);
    endfunction

    function automatic logic [2:0] gen_c(input int i);
        return 3'(i + 1);
    endfunction

    // Advance one clock; model the clients (plot at age 1..3, done at age 5),
    // then log starts, frame ends and forwarded pixels.
    task automatic cycle();
        int j;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (client_start[i]) age[i] = 0;
            else if (age[i] >= 0 && age[i] < 1000) age[i]++;
            client_plot[i] = (age[i] >= 1 && age[i] <= 3) || (i == 0 && rogue0);
            client_done[i] = (age[i] == 5) && !hang[i];
            if (age[i] >= 1 && age[i] <= 3) begin
                client_x[8*i +: 8]     = gen_x(i, age[i]);
                client_y[8*i +: 8]     = gen_y(i);
                client_color[3*i +: 3] = gen_c(i);
            end else begin
                client_x[8*i +: 8]     = (i == 0 && rogue0) ? 8'hEE : 8'h00;
                client_y[8*i +: 8]     = (i == 0 && rogue0) ? 8'hEE : 8'h00;
                client_color[3*i +: 3] = (i == 0 && rogue0) ? 3'd7 : 3'd0;
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            if (client_start[i]) begin
                start_cyc.push_back(cyc);
                start_idx.push_back(i);
            end
        end
        if (frame_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (plotPixel) begin
            j = -1;
            for (int i = 0; i < 4; i++) if (age[i] >= 1 && age[i] <= 3) j = i;
            if (j < 0) begin
                check_eq("plot_spurious", plotPixel, 1'b0);
            end else begin
                pix_cnt++;
                check_eq("pix_x", x, gen_x(j, age[j]));
                check_eq("pix_y", y, gen_y(j));
                check_eq("pix_color", color, gen_c(j));
            end
        end
    endtask

    task automatic clear_log();
        start_cyc.delete();
        start_idx.delete();
        done_cnt = 0;
        last_done_cyc = -1;
        pix_cnt = 0;
    endtask

    task automatic pulse_frame();
        frameClk = 1'b1;
        t0 = cyc;
        cycle();
        frameClk = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        n0 = done_cnt;
        for (int k = 0; k < budget && done_cnt == n0; k++) cycle();
        check_eq("wait_frame_done", done_cnt, n0 + 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            age[i]  = -1;
            hang[i] = 1'b0;
        end

        // Reset state
        resetn = 1'b0;
        repeat (3) cycle();
        check_eq("rst_grant", grant, 0);
        check_eq("rst_start", client_start, 0);
        check_eq("rst_busy", frame_busy, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_count", frame_count, 0);
        check_eq("rst_tmo", timeout_err, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_plot", plotPixel, 0);
        check_eq("rst_xyc", {x, y, 5'd0, color}, 0);
        resetn = 1'b1;
        enable = 1'b1;
        cycle();

        // Full frame, all clients
        clear_log();
        client_mask = 4'b1111;
        pulse_frame();
        check_eq("full_grant0", grant, 4'b0001);
        check_eq("full_busy_t1", frame_busy, 1);
        wait_done(100);
        check_eq("full_nstart", start_cyc.size(), 4);
        if (start_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check_eq("full_start_idx", start_idx[k], k);
                check_eq("full_start_cyc", start_cyc[k], t0 + 1 + 6 * k);
            end
        end
        check_eq("full_done_cyc", last_done_cyc, t0 + 25);
        check_eq("full_busy_end", frame_busy, 0);
        check_eq("full_pix", pix_cnt, 12);
        check_eq("full_count", frame_count, 1);

        // Sparse mask with a rogue plot strobe on client 0
        clear_log();
        rogue0 = 1'b1;
        client_mask = 4'b1010;
        pulse_frame();
        check_eq("sparse_grant", grant, 4'b0010);
        wait_done(100);
        rogue0 = 1'b0;
        check_eq("sparse_nstart", start_cyc.size(), 2);
        if (start_cyc.size() == 2) begin
            check_eq("sparse_idx0", start_idx[0], 1);
            check_eq("sparse_cyc0", start_cyc[0], t0 + 1);
            check_eq("sparse_idx1", start_idx[1], 3);
            check_eq("sparse_cyc1", start_cyc[1], t0 + 7);
        end
        check_eq("sparse_pix", pix_cnt, 6);
        check_eq("sparse_count", frame_count, 2);

        // Empty mask
        clear_log();
        client_mask = 4'b0000;
        pulse_frame();
        check_eq("empty_done", frame_done, 1);
        check_eq("empty_busy", frame_busy, 0);
        check_eq("empty_count", frame_count, 3);
        cycle();
        check_eq("empty_done_off", frame_done, 0);
        check_eq("empty_busy2", frame_busy, 0);
        check_eq("empty_nstart", start_cyc.size(), 0);

        // Watchdog: client 2 never finishes
        clear_log();
        hang[2] = 1'b1;
        client_mask = 4'b1111;
        pulse_frame();
        check_eq("wd_tmo_before", timeout_err, 0);
        wait_done(200);
        hang[2] = 1'b0;
        check_eq("wd_nstart", start_cyc.size(), 4);
        if (start_cyc.size() == 4) begin
            check_eq("wd_cyc2", start_cyc[2], t0 + 13);
            check_eq("wd_idx3", start_idx[3], 3);
            check_eq("wd_cyc3", start_cyc[3], t0 + 30);
        end
        check_eq("wd_done_cyc", last_done_cyc, t0 + 36);
        check_eq("wd_tmo", timeout_err, 1);
        check_eq("wd_count", frame_count, 4);
        clear_log();
        client_mask = 4'b0001;
        pulse_frame();
        wait_done(50);
        check_eq("wd_tmo_sticky", timeout_err, 1);
        check_eq("wd_count2", frame_count, 5);

        // Enable low in IDLE
        clear_log();
        enable = 1'b0;
        client_mask = 4'b1111;
        pulse_frame();
        check_eq("en_start", client_start, 0);
        check_eq("en_busy", frame_busy, 0);
        check_eq("en_ovr", overrun, 0);
        repeat (3) cycle();
        check_eq("en_nstart", start_cyc.size(), 0);
        check_eq("en_ndone", done_cnt, 0);
        check_eq("en_count", frame_count, 5);
        enable = 1'b1;

        // Overrun during WAIT, then a start in the frame_done cycle
        clear_log();
        client_mask = 4'b0001;
        pulse_frame();
        cycle();
        cycle();
        frameClk = 1'b1;
        cycle();
        frameClk = 1'b0;
        check_eq("ovr_flag", overrun, 1);
        wait_done(50);
        check_eq("ovr_done_cyc", last_done_cyc, t0 + 7);
        check_eq("ovr_nstart", start_cyc.size(), 1);
        check_eq("ovr_ndone", done_cnt, 1);
        check_eq("ovr_count", frame_count, 6);
        check_eq("ovr_done_now", frame_done, 1);
        pulse_frame();
        check_eq("ovr_restart", client_start, 4'b0001);
        check_eq("ovr_restart_busy", frame_busy, 1);
        wait_done(50);
        check_eq("ovr_count2", frame_count, 7);
        check_eq("ovr_sticky", overrun, 1);

        // Reset during WAIT of client 1
        clear_log();
        client_mask = 4'b1111;
        pulse_frame();
        repeat (8) cycle();
        check_eq("mid_grant", grant, 4'b0010);
        check_eq("mid_busy", frame_busy, 1);
        resetn = 1'b0;
        cycle();
        check_eq("mid_rst_grant", grant, 0);
        check_eq("mid_rst_start", client_start, 0);
        check_eq("mid_rst_busy", frame_busy, 0);
        check_eq("mid_rst_done", frame_done, 0);
        check_eq("mid_rst_count", frame_count, 0);
        check_eq("mid_rst_flags", {timeout_err, overrun}, 0);
        check_eq("mid_rst_plot", plotPixel, 0);
        check_eq("mid_rst_xyc", {x, y, 5'd0, color}, 0);
        resetn = 1'b1;
        repeat (10) cycle();
        check_eq("mid_ndone", done_cnt, 0);
        check_eq("mid_busy_after", frame_busy, 0);

        // frame_count wrap with back-to-back empty frames
        clear_log();
        client_mask = 4'b0000;
        frameClk = 1'b1;
        repeat (65535) cycle();
        check_eq("wrap_ffff", frame_count, 16'hFFFF);
        cycle();
        frameClk = 1'b0;
        check_eq("wrap_zero", frame_count, 0);
        check_eq("wrap_ndone", done_cnt, 65536);
        check_eq("wrap_busy", frame_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
